vram_arbiter: RTL and testbench

- Owns the single-port video SRAM and shares it between two requesters: the command receiver's write stream (address + byte per data strobe) and the scanout read path.
- Write requests are buffered in a small FIFO so the command link never stalls.
- Scanout reads have priority, with a starvation guard for writes.
- Sits between the command receiver/scanout logic and the external SRAM pins.

---
 rtl/vram_pkg.sv | 11 +
 rtl/vram_wr_fifo.sv | 41 ++++
 rtl/vram_arbiter.sv | 112 +++++++++++
 tb/tb_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared state encoding, default access length and FIFO entry sizing for the VRAM arbiter.
package vram_pkg;
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam int DefAccCyc = 2;
  typedef enum logic [1:0] {Idle = StIdle, Read = StRead, Write = StWrite} vramState_t;
  function automatic int entryWidth(input int aw, input int dw);
    return aw + dw;
  endfunction
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous write-request FIFO; a push into a full FIFO is accepted only alongside a pop.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int FDEPTHLOG2 = 2,
  parameter int WIDTH = entryWidth(18, 8)
) (
  input  logic                  ClkIn,
  input  logic                  ResetNIn,
  input  logic                  PushIn,
  input  logic [WIDTH-1:0]      PushDataIn,
  input  logic                  PopIn,
  output logic [WIDTH-1:0]      HeadDataOut,
  output logic                  FullOut,
  output logic                  EmptyOut,
  output logic [FDEPTHLOG2:0]   CountOut
);
  localparam int Depth = 1 << FDEPTHLOG2;
  logic [WIDTH-1:0] mem [Depth];
  logic [FDEPTHLOG2-1:0] rdPtr, wrPtr;
  logic doPush, doPop;
  assign FullOut = CountOut == (FDEPTHLOG2+1)'(Depth);
  assign EmptyOut = CountOut == '0;
  assign doPop = PopIn && !EmptyOut;
  assign doPush = PushIn && (!FullOut || doPop);
  assign HeadDataOut = mem[rdPtr];
  always_ff @(posedge ClkIn) begin
    if (doPush) mem[wrPtr] <= PushDataIn;
  end
  always_ff @(posedge ClkIn) begin
    if (!ResetNIn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      CountOut <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      CountOut <= CountOut + (FDEPTHLOG2+1)'(doPush) - (FDEPTHLOG2+1)'(doPop);
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video SRAM between buffered command writes and scanout reads.
// Reads win the Idle grant unless the write FIFO is full; every access is followed by one Idle turnaround cycle.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 8,
  parameter int FDEPTHLOG2 = 2,
  parameter int ACCCYC = DefAccCyc
) (
  input  logic              ClkIn,
  input  logic              ResetNIn,
  input  logic              WrStrobeIn,
  input  logic [AWIDTH-1:0] WrAddrIn,
  input  logic [DWIDTH-1:0] WrDataIn,
  output logic              WrFullOut,
  output logic              WrOverflowOut,
  input  logic              RdReqIn,
  input  logic [AWIDTH-1:0] RdAddrIn,
  output logic              RdAckOut,
  output logic              RdValidOut,
  output logic [DWIDTH-1:0] RdDataOut,
  output logic [AWIDTH-1:0] SramAddrOut,
  output logic [DWIDTH-1:0] SramDataOut,
  output logic              SramDataOeOut,
  input  logic [DWIDTH-1:0] SramDataIn,
  output logic              SramWeNOut,
  output logic              SramOeNOut
);
  localparam int Ew = entryWidth(AWIDTH, DWIDTH);
  localparam int Cw = $clog2(ACCCYC);
  localparam int Depth = 1 << FDEPTHLOG2;
  vramState_t state;
  logic [Cw-1:0] accCnt;
  logic [Ew-1:0] headData;
  logic [FDEPTHLOG2:0] fifoCount;
  logic fifoEmpty, wrGrant, rdGrant, lastCyc, holdCyc, dropWr;
  // A full FIFO forces a write grant so a continuous scanout stream cannot starve the command link.
  assign wrGrant = state == Idle && !fifoEmpty && (fifoCount == (FDEPTHLOG2+1)'(Depth) || !RdReqIn);
  assign rdGrant = state == Idle && !wrGrant && RdReqIn;
  assign lastCyc = accCnt == Cw'(ACCCYC - 1);
  assign holdCyc = accCnt == Cw'(ACCCYC - 2);
  assign dropWr = WrStrobeIn && WrFullOut && !wrGrant;
  vram_wr_fifo #(
    .FDEPTHLOG2(FDEPTHLOG2),
    .WIDTH(Ew)
  ) wrFifo (
    .ClkIn(ClkIn),
    .ResetNIn(ResetNIn),
    .PushIn(WrStrobeIn),
    .PushDataIn({WrAddrIn, WrDataIn}),
    .PopIn(wrGrant),
    .HeadDataOut(headData),
    .FullOut(WrFullOut),
    .EmptyOut(fifoEmpty),
    .CountOut(fifoCount)
  );
  always_ff @(posedge ClkIn) begin
    if (!ResetNIn) begin
      state <= Idle;
      accCnt <= '0;
      SramWeNOut <= 1'b1;
      SramOeNOut <= 1'b1;
      SramDataOeOut <= 1'b0;
      SramAddrOut <= '0;
      SramDataOut <= '0;
      RdAckOut <= 1'b0;
      RdValidOut <= 1'b0;
      RdDataOut <= '0;
      WrOverflowOut <= 1'b0;
    end else begin
      RdAckOut <= 1'b0;
      RdValidOut <= 1'b0;
      if (dropWr) WrOverflowOut <= 1'b1;
      case (state)
        Idle: begin
          accCnt <= '0;
          if (wrGrant) begin
            state <= Write;
            {SramAddrOut, SramDataOut} <= headData;
            SramDataOeOut <= 1'b1;
            SramWeNOut <= 1'b0;
          end else if (rdGrant) begin
            state <= Read;
            SramAddrOut <= RdAddrIn;
            SramOeNOut <= 1'b0;
            RdAckOut <= 1'b1;
          end
        end
        Read: begin
          accCnt <= accCnt + 1'b1;
          if (lastCyc) begin
            state <= Idle;
            SramOeNOut <= 1'b1;
            RdDataOut <= SramDataIn;
            RdValidOut <= 1'b1;
          end
        end
        Write: begin
          accCnt <= accCnt + 1'b1;
          // WeN rises one cycle early so address and data are held across its rising edge.
          if (holdCyc) SramWeNOut <= 1'b1;
          if (lastCyc) begin
            state <= Idle;
            SramDataOeOut <= 1'b0;
          end
        end
        default: state <= Idle;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus against a transaction-level model of the arbiter and an SRAM array.
module tb_vram_arbiter;
  localparam int ACC = 2;
  localparam int DEPTH = 4;
  logic ClkIn, ResetNIn, WrStrobeIn, WrFullOut, WrOverflowOut, RdReqIn, RdAckOut, RdValidOut;
  logic SramDataOeOut, SramWeNOut, SramOeNOut;
  logic [17:0] WrAddrIn, RdAddrIn, SramAddrOut;
  logic [7:0] WrDataIn, RdDataOut, SramDataOut, SramDataIn;
  logic [7:0] sram [1 << 18];
  int checks = 0, failures = 0;

  typedef struct packed {logic [17:0] a; logic [7:0] d;} ent_t;
  ent_t wq[$];
  ent_t ent;
  int kind = 0, k = 0;
  logic [17:0] mAddr = 0;
  logic [7:0] mData = 0, mRd = 0;
  logic mOvf = 0;

  int cyc = 0, weLow = 0, oeLow = 0, ackCnt = 0, doeCnt = 0, nk = 0;
  int startKind[$], startCyc[$];
  logic prevDoe = 0, armFull = 0, fullSeen = 0;
  int afterFullKind = 0;

  vram_arbiter dut (
    .ClkIn(ClkIn), .ResetNIn(ResetNIn), .WrStrobeIn(WrStrobeIn), .WrAddrIn(WrAddrIn),
    .WrDataIn(WrDataIn), .WrFullOut(WrFullOut), .WrOverflowOut(WrOverflowOut), .RdReqIn(RdReqIn),
    .RdAddrIn(RdAddrIn), .RdAckOut(RdAckOut), .RdValidOut(RdValidOut), .RdDataOut(RdDataOut),
    .SramAddrOut(SramAddrOut), .SramDataOut(SramDataOut), .SramDataOeOut(SramDataOeOut),
    .SramDataIn(SramDataIn), .SramWeNOut(SramWeNOut), .SramOeNOut(SramOeNOut)
  );

  initial ClkIn = 0;
  always #5 ClkIn = ~ClkIn;

  assign SramDataIn = SramOeNOut ? 8'h00 : sram[SramAddrOut];

  function automatic logic [7:0] pat(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each access is numbered by k (1..ACC busy, ACC+1 is the following Idle); SRAM is written after the model reads it.
  initial begin
    for (int i = 0; i < (1 << 18); i++) sram[i] = pat(18'(i));
    sram[18'h10] = 8'h3C;
    forever begin
      @(posedge ClkIn);
      if (!ResetNIn) begin
        wq.delete();
        kind = 0; k = 0; mAddr = 0; mData = 0; mRd = 0; mOvf = 0;
      end else begin
        if (kind == 0 || k >= ACC + 1) begin
          if (wq.size() > 0 && (wq.size() == DEPTH || !RdReqIn)) begin
            ent = wq.pop_front();
            kind = 2; k = 1; mAddr = ent.a; mData = ent.d;
          end else if (RdReqIn) begin
            kind = 1; k = 1; mAddr = RdAddrIn;
          end else if (kind != 0) k++;
        end else begin
          k++;
          if (kind == 1 && k == ACC + 1) mRd = sram[mAddr];
        end
        if (WrStrobeIn) begin
          if (wq.size() < DEPTH) wq.push_back({WrAddrIn, WrDataIn});
          else mOvf = 1;
        end
      end
      if (SramWeNOut === 1'b0) sram[SramAddrOut] = SramDataOut;
    end
  end

  initial forever begin
    @(posedge ClkIn);
    #1;
    cyc++;
    check("ack", 32'(RdAckOut), 32'(kind == 1 && k == 1));
    check("valid", 32'(RdValidOut), 32'(kind == 1 && k == ACC + 1));
    check("oen", 32'(SramOeNOut), 32'(!(kind == 1 && k >= 1 && k <= ACC)));
    check("wen", 32'(SramWeNOut), 32'(!(kind == 2 && k >= 1 && k < ACC)));
    check("dataoe", 32'(SramDataOeOut), 32'(kind == 2 && k >= 1 && k <= ACC));
    check("addr", 32'(SramAddrOut), 32'(mAddr));
    check("wdata", 32'(SramDataOut), 32'(mData));
    check("rdata", 32'(RdDataOut), 32'(mRd));
    check("full", 32'(WrFullOut), 32'(wq.size() == DEPTH));
    check("ovf", 32'(WrOverflowOut), 32'(mOvf));
    check("we_oe_excl", 32'(!SramWeNOut && !SramOeNOut), 0);
    if (!SramWeNOut) weLow++;
    if (!SramOeNOut) oeLow++;
    if (RdAckOut) ackCnt++;
    if (SramDataOeOut) doeCnt++;
    nk = RdAckOut ? 1 : (SramDataOeOut && !prevDoe) ? 2 : 0;
    if (nk != 0) begin
      startKind.push_back(nk);
      startCyc.push_back(cyc);
      if (fullSeen && afterFullKind == 0) afterFullKind = nk;
    end
    if (armFull && WrFullOut) fullSeen = 1;
    prevDoe = SramDataOeOut;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ClkIn);
  endtask

  task automatic push(input logic [17:0] a, input logic [7:0] d);
    WrStrobeIn = 1; WrAddrIn = a; WrDataIn = d;
    @(negedge ClkIn);
    WrStrobeIn = 0;
  endtask

  task automatic waitFor(input string name, input int which);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge ClkIn);
      #1;
      ok = which == 0 ? RdAckOut : which == 1 ? SramDataOeOut : !SramWeNOut;
    end
    check(name, 32'(ok), 1);
  endtask

  initial begin
    int n;
    ResetNIn = 0; WrStrobeIn = 0; WrAddrIn = 0; WrDataIn = 0; RdReqIn = 0; RdAddrIn = 0;
    tick(3);
    check("rst_wen", 32'(SramWeNOut), 1);
    check("rst_oen", 32'(SramOeNOut), 1);
    check("rst_dataoe", 32'(SramDataOeOut), 0);
    check("rst_full", 32'(WrFullOut), 0);
    check("rst_ovf", 32'(WrOverflowOut), 0);
    ResetNIn = 1;
    tick(2);

    weLow = 0;
    push(18'h12345, 8'hA5);
    waitFor("w1_grant", 1);
    check("w1_addr", 32'(SramAddrOut), 32'h12345);
    check("w1_data", 32'(SramDataOut), 32'hA5);
    tick(6);
    check("w1_we_cycles", weLow, 1);
    check("w1_mem", 32'(sram[18'h12345]), 32'hA5);

    oeLow = 0;
    RdAddrIn = 18'h10; RdReqIn = 1;
    waitFor("r1_ack", 0);
    @(negedge ClkIn);
    RdReqIn = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ClkIn);
      #1;
      n++;
      if (RdValidOut) break;
    end
    check("r1_latency", n, 2);
    check("r1_data", 32'(RdDataOut), 32'h3C);
    tick(3);
    check("r1_oe_cycles", oeLow, 2);

    startKind.delete(); startCyc.delete();
    RdAddrIn = 18'h30; RdReqIn = 1;
    waitFor("p_ack1", 0);
    @(negedge ClkIn);
    RdAddrIn = 18'h40;
    push(18'h00200, 8'h21);
    push(18'h00201, 8'h22);
    waitFor("p_ack2", 0);
    @(negedge ClkIn);
    RdReqIn = 0;
    tick(15);
    check("p_count", startKind.size(), 4);
    if (startKind.size() == 4) begin
      check("p_order", startKind[0] * 4096 + startKind[1] * 256 + startKind[2] * 16 + startKind[3], 32'h1122);
      for (int i = 1; i < 4; i++) check("p_gap", startCyc[i] - startCyc[i-1], ACC + 1);
    end
    check("p_mem", 32'(sram[18'h00201]), 32'h22);

    armFull = 1; fullSeen = 0; afterFullKind = 0;
    RdAddrIn = 18'h50; RdReqIn = 1;
    for (int i = 0; i < 4; i++) push(18'h00300 + 18'(i), 8'h30 + 8'(i));
    tick(12);
    check("s_full_seen", 32'(fullSeen), 1);
    check("s_after_full", afterFullKind, 2);
    waitFor("s_ack", 0);
    @(negedge ClkIn);
    RdReqIn = 0; armFull = 0;
    tick(20);
    check("s_drained", 32'(WrFullOut), 0);
    check("s_mem", 32'(sram[18'h00303]), 32'h33);

    RdAddrIn = 18'h60; RdReqIn = 1;
    waitFor("o_ack", 0);
    @(negedge ClkIn);
    for (int i = 1; i <= 5; i++) push(18'h3F000 + 18'(i), 8'hC0 + 8'(i));
    tick(4);
    check("o_ovf", 32'(WrOverflowOut), 1);
    waitFor("o_ack2", 0);
    @(negedge ClkIn);
    RdReqIn = 0;
    tick(30);
    check("o_ovf_sticky", 32'(WrOverflowOut), 1);
    check("o_kept4", 32'(sram[18'h3F004]), 32'hC4);
    check("o_drop5", 32'(sram[18'h3F005]), 32'(pat(18'h3F005)));

    ackCnt = 0;
    push(18'h00400, 8'h44);
    waitFor("x_grant", 1);
    @(negedge ClkIn);
    RdAddrIn = 18'h70; RdReqIn = 1;
    @(negedge ClkIn);
    RdReqIn = 0;
    tick(10);
    check("x_no_ack", ackCnt, 0);

    for (int i = 0; i < 3; i++) push(18'h00500 + 18'(i), 8'h50 + 8'(i));
    waitFor("m_wen", 2);
    @(negedge ClkIn);
    ResetNIn = 0;
    @(posedge ClkIn);
    #1;
    check("m_wen_high", 32'(SramWeNOut), 1);
    check("m_dataoe", 32'(SramDataOeOut), 0);
    check("m_oen", 32'(SramOeNOut), 1);
    check("m_full", 32'(WrFullOut), 0);
    check("m_ovf", 32'(WrOverflowOut), 0);
    check("m_addr", 32'(SramAddrOut), 0);
    check("m_rdata", 32'(RdDataOut), 0);
    @(negedge ClkIn);
    ResetNIn = 1;
    doeCnt = 0;
    tick(10);
    check("m_fifo_empty", doeCnt, 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
